// File: rtl/key_conditioner_if.sv
// Key bundle between the front-panel key conditioner and the clock top level.
interface key_conditioner_if #(
    parameter int unsigned N_KEYS = 9
) ();
    logic [N_KEYS-1:0] KEY_IN;
    logic [N_KEYS-1:0] KEY_PULSE;
    logic [N_KEYS-1:0] KEY_LEVEL;

    modport master (output KEY_IN, input KEY_PULSE, input KEY_LEVEL);
    modport slave  (input KEY_IN, output KEY_PULSE, output KEY_LEVEL);
endinterface

// File: rtl/key_conditioner.sv
// Per-key 2-flop synchronizer, debounce FSM, press pulse and held level.
// Auto-repeat (REPEAT state, hold/repeat timers) is built only when KEY_REPEAT_EN is defined.
module key_conditioner #(
    parameter int unsigned N_KEYS      = 9,
    parameter int unsigned DB_CYCLES   = 200,
    parameter int unsigned HOLD_CYCLES = 5000,
    parameter int unsigned RPT_CYCLES  = 1000
) (
    input  logic             CP,
    input  logic             CR,
    key_conditioner_if.slave kif
);

    localparam int unsigned MAX_AB  = (DB_CYCLES > HOLD_CYCLES) ? DB_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_AB > RPT_CYCLES) ? MAX_AB : RPT_CYCLES;
    localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] RPT_LAST  = CW'(RPT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HELD,
`ifdef KEY_REPEAT_EN
        REPEAT,
`endif
        RELEASE_DB
    } state_t;

    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] sync2_q;

    always_ff @(posedge CP) begin
        if (CR) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= kif.KEY_IN;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          pulse_q, pulse_d;
        logic          level_q, level_d;
        logic          s;

        assign s = sync2_q[i];

        always_ff @(posedge CP) begin
            if (CR) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
                level_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pulse_q <= pulse_d;
                level_q <= level_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pulse_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (s) begin
                        state_d = PRESS_DB;
                        cnt_d   = '0;
                    end
                end
                PRESS_DB: begin
                    if (!s) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                HELD: begin
                    if (!s) begin
                        state_d = RELEASE_DB;
                        cnt_d   = '0;
                    end
`ifdef KEY_REPEAT_EN
                    else if (cnt_q == HOLD_LAST) begin
                        state_d = REPEAT;
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
`endif
                end
`ifdef KEY_REPEAT_EN
                REPEAT: begin
                    if (!s) begin
                        state_d = RELEASE_DB;
                        cnt_d   = '0;
                    end else if (cnt_q == RPT_LAST) begin
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`endif
                RELEASE_DB: begin
                    // A bounce back to 1 re-enters HELD, restarting the hold timer.
                    if (s) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
            level_d = (state_d != IDLE) && (state_d != PRESS_DB);
        end

        assign kif.KEY_PULSE[i] = pulse_q;
        assign kif.KEY_LEVEL[i] = level_q;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: run-length reference model checked every cycle, plus pinned timings.
module tb_key_conditioner;
    localparam int N    = 9;
    localparam int DB   = 4;
    localparam int HOLD = 10;
    localparam int RPT  = 3;
`ifdef KEY_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic clk = 1'b0;
    logic cr  = 1'b1;
    logic [N-1:0] kin = '0;
    always #5 clk = ~clk;

    key_conditioner_if #(.N_KEYS(N)) kif ();
    assign kif.KEY_IN = kin;

    key_conditioner #(
        .N_KEYS(N), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .RPT_CYCLES(RPT)
    ) dut (
        .CP(clk), .CR(cr), .kif(kif)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: the FSM sees KEY_IN from two edges back; a level change needs
    // DB+1 consecutive equal samples; repeats are timed from acceptance or from the
    // last cancelled release.
    bit d1[N], d2[N], lvl[N];
    int ones[N], zeros[N], el[N];
    logic [N-1:0] exp_pulse = '0;
    logic [N-1:0] exp_level = '0;

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < N; i++) begin
            bit s;
            bit p;
            p = 1'b0;
            if (cr) begin
                d1[i] = 0; d2[i] = 0; lvl[i] = 0; ones[i] = 0; zeros[i] = 0; el[i] = 0;
            end else begin
                s = d2[i];
                d2[i] = d1[i];
                d1[i] = kin[i];
                if (s) begin ones[i]++; zeros[i] = 0; end
                else   begin zeros[i]++; ones[i] = 0; end
                if (!lvl[i]) begin
                    if (ones[i] == DB + 1) begin lvl[i] = 1; p = 1'b1; el[i] = 0; end
                end else if (s) begin
                    if (ones[i] == 1) el[i] = 0;
                    else begin
                        el[i]++;
                        if (REP && (el[i] == HOLD || (el[i] > HOLD && (el[i] - HOLD) % RPT == 0)))
                            p = 1'b1;
                    end
                end else if (zeros[i] == DB + 1) begin
                    lvl[i] = 0;
                end
            end
            exp_pulse[i] = p;
            exp_level[i] = lvl[i];
        end
    end

    int plog[N][$];
    int qrise[N][$];
    int qfall[N][$];
    logic [N-1:0] prev_lvl = '0;

    always @(negedge clk) begin
        tests++;
        if (kif.KEY_PULSE !== exp_pulse) begin
            fails++;
            $display("FAIL pulse cyc=%0d got %b expected %b", cyc, kif.KEY_PULSE, exp_pulse);
        end
        tests++;
        if (kif.KEY_LEVEL !== exp_level) begin
            fails++;
            $display("FAIL level cyc=%0d got %b expected %b", cyc, kif.KEY_LEVEL, exp_level);
        end
        for (int i = 0; i < N; i++) begin
            if (kif.KEY_PULSE[i] === 1'b1) plog[i].push_back(cyc);
            if (kif.KEY_LEVEL[i] === 1'b1 && !prev_lvl[i]) qrise[i].push_back(cyc);
            if (kif.KEY_LEVEL[i] === 1'b0 && prev_lvl[i]) qfall[i].push_back(cyc);
        end
        prev_lvl = kif.KEY_LEVEL;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    int p0, rel0, p2, p5;
    int exp_off[7] = '{0, 10, 13, 16, 19, 22, 25};
    bit bounce_pat[7] = '{1, 1, 0, 1, 1, 1, 0};

    initial begin
        wait_cycles(3);
        check("reset_pulse", int'(kif.KEY_PULSE), 0);
        check("reset_level", int'(kif.KEY_LEVEL), 0);
        cr = 1'b0;
        wait_cycles(2);

        // Clean press of key 0, held 6 cycles
        kin[0] = 1'b1; p0 = cyc + 1;
        wait_cycles(6);
        kin[0] = 1'b0; rel0 = cyc + 1;
        wait_cycles(15);
        check("k0_npulse", plog[0].size(), 1);
        if (plog[0].size() > 0) check("k0_pulse_cyc", plog[0][0], p0 + 6);
        check("k0_nrise", qrise[0].size(), 1);
        if (qrise[0].size() > 0) check("k0_rise_cyc", qrise[0][0], p0 + 6);
        if (qfall[0].size() > 0) check("k0_fall_cyc", qfall[0][0], rel0 + 6);
        else check("k0_nfall", 0, 1);

        // Bounce on key 1 never accepted
        for (int j = 0; j < 7; j++) begin
            kin[1] = bounce_pat[j];
            wait_cycles(1);
        end
        kin[1] = 1'b0;
        wait_cycles(10);
        check("k1_npulse", plog[1].size(), 0);
        check("k1_nrise", qrise[1].size(), 0);

        // Long hold of key 2
        kin[2] = 1'b1; p2 = cyc + 1;
        wait_cycles(30);
        kin[2] = 1'b0;
        wait_cycles(15);
        check("k2_npulse", plog[2].size(), REP ? 7 : 1);
        for (int j = 0; j < plog[2].size() && j < 7; j++)
            check("k2_pulse_off", plog[2][j] - (p2 + 6), exp_off[j]);

        // Keys 3 and 4 together
        kin[3] = 1'b1; kin[4] = 1'b1;
        wait_cycles(10);
        kin[3] = 1'b0; kin[4] = 1'b0;
        wait_cycles(12);
        check("k3_npulse", plog[3].size(), 1);
        check("k4_npulse", plog[4].size(), 1);
        if (plog[3].size() > 0 && plog[4].size() > 0)
            check("k34_same_cyc", plog[3][0], plog[4][0]);

        // Reset while key 5 is held, then re-debounce
        kin[5] = 1'b1; p5 = cyc + 1;
        wait_cycles(8);
        cr = 1'b1;
        wait_cycles(1);
        check("k5_cr_level", int'(kif.KEY_LEVEL[5]), 0);
        cr = 1'b0;
        wait_cycles(20);
        kin[5] = 1'b0;
        wait_cycles(15);
        check("k5_npulse_ge2", int'(plog[5].size() >= 2), 1);
        if (plog[5].size() >= 2) begin
            check("k5_first", plog[5][0], p5 + 6);
            check("k5_after_cr", plog[5][1], p5 + 15);
        end

        // Randomized phase: per-key bounce rates, occasional reset
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                int unsigned rate;
                rate = (i % 3 == 0) ? 3 : ((i % 3 == 1) ? 12 : 40);
                if ($urandom_range(rate - 1, 0) == 0) kin[i] = ~kin[i];
            end
            cr = ($urandom_range(699, 0) == 0);
            wait_cycles(1);
        end
        cr = 1'b0;
        kin = '0;
        wait_cycles(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
